pipelined_carry_select_adder: RTL and testbench

Parametrised, pipelined carry-select adder/subtractor with valid/ready flow control. Splits the operands into BLOCK_SIZE-bit carry-select blocks and registers the partial result after every BLOCKS_PER_STAGE blocks. This gives a configurable latency/frequency trade-off for datapaths that outgrow the single-cycle combinational carry-select adder. Adds subtract mode, a signed-overflow flag and back-pressure.

---
 rtl/pipelined_carry_select_adder.sv | 138 +++++++++++++
 tb/tb_pipelined_carry_select_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_carry_select_adder.sv
// Pipelined carry-select adder/subtractor with valid/ready flow control.
// Each pipeline stage resolves BLOCKS_PER_STAGE carry-select blocks and forwards the unresolved operand slices.
module pipelined_carry_select_adder #(
    parameter int OPERAND_SIZE     = 16,
    parameter int BLOCK_SIZE       = 4,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPERAND_SIZE-1:0] A,
    input  logic [OPERAND_SIZE-1:0] B,
    input  logic                    Cin,
    input  logic                    Sub,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OPERAND_SIZE-1:0] Sout,
    output logic                    Cout,
    output logic                    Ovf
);

    localparam int NUM_BLOCKS = OPERAND_SIZE / BLOCK_SIZE;
    localparam int LATENCY    = NUM_BLOCKS / BLOCKS_PER_STAGE;
    localparam int MSB        = OPERAND_SIZE - 1;

    typedef struct packed {
        logic [OPERAND_SIZE-1:0] sum;
        logic                    carry;
    } stage_res_t;

    // Both block sums are formed before the incoming carry is known; the carry only drives the mux.
    function automatic stage_res_t stage_add(
        input int                      stage,
        input logic [OPERAND_SIZE-1:0] a,
        input logic [OPERAND_SIZE-1:0] b,
        input logic [OPERAND_SIZE-1:0] sum_in,
        input logic                    carry_in
    );
        stage_res_t          res;
        logic [BLOCK_SIZE:0] sum0;
        logic [BLOCK_SIZE:0] sum1;
        logic [BLOCK_SIZE:0] sel;
        logic                carry;
        int                  base;
        res.sum = sum_in;
        carry   = carry_in;
        for (int j = 0; j < BLOCKS_PER_STAGE; j++) begin
            base = (stage * BLOCKS_PER_STAGE + j) * BLOCK_SIZE;
            sum0 = {1'b0, a[base +: BLOCK_SIZE]} + {1'b0, b[base +: BLOCK_SIZE]};
            sum1 = sum0 + (BLOCK_SIZE + 1)'(1);
            sel  = carry ? sum1 : sum0;
            res.sum[base +: BLOCK_SIZE] = sel[BLOCK_SIZE-1:0];
            carry = sel[BLOCK_SIZE];
        end
        res.carry = carry;
        return res;
    endfunction

    logic [OPERAND_SIZE-1:0] r_a     [LATENCY];
    logic [OPERAND_SIZE-1:0] r_b     [LATENCY];
    logic [OPERAND_SIZE-1:0] r_sum   [LATENCY];
    logic                    r_carry [LATENCY];
    logic [LATENCY-1:0]      r_valid;
    logic                    r_ovf;

    logic [OPERAND_SIZE-1:0] w_in_a   [LATENCY];
    logic [OPERAND_SIZE-1:0] w_in_b   [LATENCY];
    logic [OPERAND_SIZE-1:0] w_in_sum [LATENCY];
    logic                    w_in_c   [LATENCY];
    stage_res_t              w_res    [LATENCY];
    logic [OPERAND_SIZE-1:0] w_bx;
    logic                    w_c0;
    logic                    w_en;
    logic                    w_msb_cin;
    logic                    w_ovf;

    assign w_bx = Sub ? ~B : B;
    assign w_c0 = Sub ? ~Cin : Cin;

    for (genvar k = 0; k < LATENCY; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_in_a[k]   = A;
            assign w_in_b[k]   = w_bx;
            assign w_in_sum[k] = '0;
            assign w_in_c[k]   = w_c0;
        end else begin : g_next
            assign w_in_a[k]   = r_a[k-1];
            assign w_in_b[k]   = r_b[k-1];
            assign w_in_sum[k] = r_sum[k-1];
            assign w_in_c[k]   = r_carry[k-1];
        end
        assign w_res[k] = stage_add(k, w_in_a[k], w_in_b[k], w_in_sum[k], w_in_c[k]);
    end

    // Sum bit = a ^ b ^ carry_in, so the carry into the MSB falls out of the final block's sum bit.
    assign w_msb_cin = w_in_a[LATENCY-1][MSB] ^ w_in_b[LATENCY-1][MSB] ^ w_res[LATENCY-1].sum[MSB];
    assign w_ovf     = w_msb_cin ^ w_res[LATENCY-1].carry;

    assign w_en      = ~r_valid[LATENCY-1] | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_valid[LATENCY-1];
    assign Sout      = r_sum[LATENCY-1];
    assign Cout      = r_carry[LATENCY-1];
    assign Ovf       = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < LATENCY; k++) begin
                r_sum[k]   <= '0;
                r_carry[k] <= 1'b0;
            end
        end else if (w_en) begin
            r_valid[0] <= in_valid;
            for (int k = 1; k < LATENCY; k++) begin
                r_valid[k] <= r_valid[k-1];
            end
            for (int k = 0; k < LATENCY; k++) begin
                r_sum[k]   <= w_res[k].sum;
                r_carry[k] <= w_res[k].carry;
            end
            r_ovf <= w_ovf;
        end
    end

    // NOTE: the operand slices are qualified by the valid bits, so they carry no reset and cost no reset fan-out.
    always_ff @(posedge clk) begin
        if (w_en) begin
            for (int k = 0; k < LATENCY; k++) begin
                r_a[k] <= w_in_a[k];
                r_b[k] <= w_in_b[k];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_carry_select_adder.sv
// Self-checking bench: directed vectors on the default configuration plus a 32/8/1 instance.
module tb_pipelined_carry_select_adder;

    localparam int W  = 16;
    localparam int WW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  A, B, Sout;
    logic          Cin, Sub, Cout, Ovf;

    logic          in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [WW-1:0] A_w, B_w, Sout_w;
    logic          Cin_w, Sub_w, Cout_w, Ovf_w;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [W-1:0] a, b;
        logic         cin, sub;
        logic [W-1:0] s;
        logic         c, o;
    } vec_t;

    pipelined_carry_select_adder u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .Sub(Sub), .out_valid(out_valid), .out_ready(out_ready),
        .Sout(Sout), .Cout(Cout), .Ovf(Ovf)
    );

    pipelined_carry_select_adder #(.OPERAND_SIZE(32), .BLOCK_SIZE(8), .BLOCKS_PER_STAGE(1)) u_dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .A(A_w), .B(B_w), .Cin(Cin_w), .Sub(Sub_w), .out_valid(out_valid_w), .out_ready(out_ready_w),
        .Sout(Sout_w), .Cout(Cout_w), .Ovf(Ovf_w)
    );

    function automatic logic [W+1:0] golden(input logic [W-1:0] a, b, input logic cin, sub);
        logic [W-1:0] bx;
        logic         c0;
        logic [W:0]   full;
        logic         ovf;
        bx   = sub ? ~b : b;
        c0   = sub ^ cin;
        full = {1'b0, a} + {1'b0, bx} + {{W{1'b0}}, c0};
        ovf  = (a[W-1] == bx[W-1]) && (full[W-1] != a[W-1]);
        return {ovf, full[W], full[W-1:0]};
    endfunction

    // Sends one op into an empty pipe and waits (bounded) for its result.
    task automatic send_one(input logic [W-1:0] a, b, input logic cin, sub,
                            output logic [W-1:0] s, output logic c, o, output int lat);
        @(negedge clk);
        A = a; B = b; Cin = cin; Sub = sub; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = Sout; c = Cout; o = Ovf;
    endtask

    task automatic send_one_w(input logic [WW-1:0] a, b, input logic cin, sub,
                              output logic [WW-1:0] s, output logic c, o, output int lat);
        @(negedge clk);
        A_w = a; B_w = b; Cin_w = cin; Sub_w = sub; in_valid_w = 1'b1; out_ready_w = 1'b1;
        @(negedge clk);
        in_valid_w = 1'b0;
        lat = 1;
        while (!out_valid_w && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        s = Sout_w; c = Cout_w; o = Ovf_w;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b, expected 0", out_valid); end
        n_checks++; if (Sout !== 16'h0000) begin n_errors++; $display("FAIL reset_sout: got %h, expected 0000", Sout); end
        n_checks++; if ({Cout, Ovf} !== 2'b00) begin n_errors++; $display("FAIL reset_cout_ovf: got %b, expected 00", {Cout, Ovf}); end
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b, expected 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_no_ghost: got %b, expected 0", out_valid); end
        n_checks++; if (out_valid_w !== 1'b0) begin n_errors++; $display("FAIL reset_wide_out_valid: got %b, expected 0", out_valid_w); end
    endtask

    task automatic test_basic_add;
        logic [W-1:0] s;
        logic         c, o;
        int           lat;
        send_one(16'h1234, 16'h0FFF, 1'b1, 1'b0, s, c, o, lat);
        n_checks++; if (lat !== 2) begin n_errors++; $display("FAIL basic_latency: got %0d, expected 2", lat); end
        n_checks++; if (s !== 16'h2234) begin n_errors++; $display("FAIL basic_sout: got %h, expected 2234", s); end
        n_checks++; if ({c, o} !== 2'b00) begin n_errors++; $display("FAIL basic_cout_ovf: got %b, expected 00", {c, o}); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL basic_one_cycle: got %b, expected 0", out_valid); end
    endtask

    task automatic test_carry_overflow;
        vec_t         v [3];
        logic [W-1:0] s;
        logic         c, o;
        int           lat;
        v[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            send_one(v[i].a, v[i].b, v[i].cin, v[i].sub, s, c, o, lat);
            n_checks++;
            if ({s, c, o, lat[3:0]} !== {v[i].s, v[i].c, v[i].o, 4'd2}) begin
                n_errors++;
                $display("FAIL carry_vec%0d: got s=%h c=%b o=%b lat=%0d, expected s=%h c=%b o=%b lat=2",
                         i, s, c, o, lat, v[i].s, v[i].c, v[i].o);
            end
        end
    endtask

    task automatic test_subtract;
        vec_t         v [4];
        logic [W-1:0] s;
        logic         c, o;
        int           lat;
        v[0] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        v[1] = '{16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0};
        v[2] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        v[3] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            send_one(v[i].a, v[i].b, v[i].cin, v[i].sub, s, c, o, lat);
            n_checks++;
            if ({s, c, o, lat[3:0]} !== {v[i].s, v[i].c, v[i].o, 4'd2}) begin
                n_errors++;
                $display("FAIL sub_vec%0d: got s=%h c=%b o=%b lat=%0d, expected s=%h c=%b o=%b lat=2",
                         i, s, c, o, lat, v[i].s, v[i].c, v[i].o);
            end
        end
    endtask

    task automatic test_back_to_back;
        vec_t v [6];
        int   tx = 0;
        int   rx = 0;
        int   stalls = 0;
        v[0] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};
        v[1] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
        v[2] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        v[3] = '{16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        v[4] = '{16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b1, 1'b0};
        v[5] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk);
            out_ready = !(cyc >= 3 && cyc < 7);
            in_valid  = (tx < 6);
            if (tx < 6) begin
                A = v[tx].a; B = v[tx].b; Cin = v[tx].cin; Sub = v[tx].sub;
            end
            #1;
            if (out_valid && !out_ready) begin
                stalls++;
                n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL stall_in_ready cyc%0d: got %b, expected 0", cyc, in_ready); end
                n_checks++;
                if (rx >= 6 || Sout !== v[rx].s) begin
                    n_errors++;
                    $display("FAIL stall_hold cyc%0d: got %h, expected head result %h", cyc, Sout, (rx < 6) ? v[rx].s : 16'h0000);
                end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (rx >= 6) begin
                    n_errors++;
                    $display("FAIL b2b_extra cyc%0d: got extra result %h, expected none", cyc, Sout);
                end else if ({Sout, Cout, Ovf} !== {v[rx].s, v[rx].c, v[rx].o}) begin
                    n_errors++;
                    $display("FAIL b2b_result%0d: got s=%h c=%b o=%b, expected s=%h c=%b o=%b",
                             rx, Sout, Cout, Ovf, v[rx].s, v[rx].c, v[rx].o);
                end
                rx++;
            end
            if (in_valid && in_ready) tx++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (rx !== 6) begin n_errors++; $display("FAIL b2b_count: got %0d results, expected 6", rx); end
        n_checks++; if (stalls !== 4) begin n_errors++; $display("FAIL b2b_stall_cycles: got %0d, expected 4", stalls); end
    endtask

    task automatic test_reset_midflight;
        logic [W-1:0] s;
        logic         c, o;
        int           lat;
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        A = 16'h3333; B = 16'h4444; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        n_checks++; if (Sout !== 16'h0000) begin n_errors++; $display("FAIL midrst_sout: got %h, expected 0000", Sout); end
        for (int i = 0; i < 6; i++) begin
            n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_ghost%0d: got %b, expected 0", i, out_valid); end
            @(negedge clk);
        end
        send_one(16'h0100, 16'h0023, 1'b0, 1'b0, s, c, o, lat);
        n_checks++;
        if ({s, c, o, lat[3:0]} !== {16'h0123, 1'b0, 1'b0, 4'd2}) begin
            n_errors++;
            $display("FAIL midrst_after: got s=%h c=%b o=%b lat=%0d, expected s=0123 c=0 o=0 lat=2", s, c, o, lat);
        end
    endtask

    task automatic test_random_sweep;
        logic [W+1:0] q [$];
        logic [W+1:0] exp_v;
        int           sent = 0;
        int           got = 0;
        int           cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
            A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); Sub = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_errors++;
                    $display("FAIL rand_unexpected: got result %h, expected none", Sout);
                end else begin
                    exp_v = q.pop_front();
                    if ({Ovf, Cout, Sout} !== exp_v) begin
                        n_errors++;
                        $display("FAIL rand_result%0d: got %h, expected %h", got, {Ovf, Cout, Sout}, exp_v);
                    end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                q.push_back(golden(A, B, Cin, Sub));
                sent++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++; if (got !== 1000) begin n_errors++; $display("FAIL rand_count: got %0d results, expected 1000", got); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_wide_latency;
        logic [WW-1:0] ta [3];
        logic [WW-1:0] tb [3];
        logic [WW-1:0] ts [3];
        logic [1:0]    tco [3];
        logic          tsub [3];
        logic [WW-1:0] s;
        logic          c, o;
        int            lat;
        ta[0] = 32'hFFFF_FFFF; tb[0] = 32'h0000_0001; tsub[0] = 1'b0; ts[0] = 32'h0000_0000; tco[0] = 2'b10;
        ta[1] = 32'h7FFF_FFFF; tb[1] = 32'h0000_0001; tsub[1] = 1'b0; ts[1] = 32'h8000_0000; tco[1] = 2'b01;
        ta[2] = 32'h0000_0005; tb[2] = 32'h0000_0007; tsub[2] = 1'b1; ts[2] = 32'hFFFF_FFFE; tco[2] = 2'b00;
        for (int i = 0; i < 3; i++) begin
            send_one_w(ta[i], tb[i], 1'b0, tsub[i], s, c, o, lat);
            n_checks++;
            if ({s, c, o, lat[3:0]} !== {ts[i], tco[i], 4'd4}) begin
                n_errors++;
                $display("FAIL wide_vec%0d: got s=%h c=%b o=%b lat=%0d, expected s=%h co=%b lat=4",
                         i, s, c, o, lat, ts[i], tco[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        A = 16'hDEAD; B = 16'hBEEF; Cin = 1'b1; Sub = 1'b0;
        in_valid_w = 1'b0; out_ready_w = 1'b1; A_w = '0; B_w = '0; Cin_w = 1'b0; Sub_w = 1'b0;
        test_reset();
        test_basic_add();
        test_carry_overflow();
        test_subtract();
        test_back_to_back();
        test_reset_midflight();
        test_random_sweep();
        test_wide_latency();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
